// File: rtl/nes_poll_controller.sv
// NES controller poller: latch strobe, seven shift pulses, eight active-low samples
// assembled into an active-high button byte, with optional periodic auto-polling.
module nes_poll_controller #(
    parameter int CLK_DIV       = 300,
    parameter int POLL_INTERVAL = 833333
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       auto_en,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       changed,
    output logic       busy
);
    localparam int PW = $clog2(2 * CLK_DIV + 1);
    localparam int AW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

    localparam logic [PW-1:0] LATCH_END = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] HALF_END  = PW'(CLK_DIV - 1);
    localparam logic [AW-1:0] AUTO_END  = AW'(POLL_INTERVAL - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LATCH    = 3'd1;
    localparam logic [2:0] GAP      = 3'd2;
    localparam logic [2:0] PULSE_HI = 3'd3;
    localparam logic [2:0] PULSE_LO = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    logic [2:0]    state;
    logic [PW-1:0] phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [AW-1:0] auto_cnt;
    logic          trigger;
    logic          accept;
    logic          phase_end;

    assign trigger   = start | (auto_en & (auto_cnt == AUTO_END));
    assign accept    = (state == IDLE) & trigger;
    assign phase_end = (state == LATCH) ? (phase == LATCH_END) : (phase == HALF_END);

    assign nes_latch = (state == LATCH);
    assign nes_pulse = (state == PULSE_HI);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            buttons <= '0;
            valid   <= 1'b0;
            changed <= 1'b0;
        end else begin
            valid   <= 1'b0;
            changed <= 1'b0;
            // One shared phase counter; it wraps at each state boundary.
            if (busy && state != DONE && !phase_end)
                phase <= phase + 1'b1;
            else
                phase <= '0;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state   <= LATCH;
                        bit_cnt <= '0;
                    end
                end
                LATCH: begin
                    if (phase_end) state <= GAP;
                end
                GAP: begin
                    if (phase_end) begin
                        shreg <= {shreg[6:0], ~nes_data};
                        state <= PULSE_HI;
                    end
                end
                PULSE_HI: begin
                    if (phase_end) state <= PULSE_LO;
                end
                PULSE_LO: begin
                    if (phase_end) begin
                        shreg   <= {shreg[6:0], ~nes_data};
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= (bit_cnt == 3'd6) ? DONE : PULSE_HI;
                    end
                end
                DONE: begin
                    buttons <= shreg;
                    valid   <= 1'b1;
                    changed <= (shreg != buttons);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Interval counter saturates so an interval that expires mid-poll fires on the first IDLE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            auto_cnt <= '0;
        else if (accept || !auto_en)
            auto_cnt <= '0;
        else if (auto_cnt != AUTO_END)
            auto_cnt <= auto_cnt + 1'b1;
    end
endmodule

// File: tb/tb_nes_poll_controller.sv
// Bench for nes_poll_controller: two instances (CLK_DIV=2/POLL=100 and CLK_DIV=1/POLL=10)
// checked every cycle against a timeline model, plus directed latency/count checks.
module tb_nes_poll_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] start_v, auto_v, data_v;
    logic       latch0, pulse0, valid0, changed0, busy0;
    logic       latch1, pulse1, valid1, changed1, busy1;
    logic [7:0] btn0, btn1;

    int vectors = 0;
    int miscompares = 0;

    nes_poll_controller #(.CLK_DIV(2), .POLL_INTERVAL(100)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .auto_en(auto_v[0]),
        .nes_data(data_v[0]), .nes_latch(latch0), .nes_pulse(pulse0),
        .buttons(btn0), .valid(valid0), .changed(changed0), .busy(busy0));

    nes_poll_controller #(.CLK_DIV(1), .POLL_INTERVAL(10)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .auto_en(auto_v[1]),
        .nes_data(data_v[1]), .nes_latch(latch1), .nes_pulse(pulse1),
        .buttons(btn1), .valid(valid1), .changed(changed1), .busy(busy1));

    // Model: a poll is a timeline t = 0..17*D (cycles after the accepting edge);
    // the byte the fake controller presents becomes buttons on the edge after t = 17*D.
    bit         active  [2];
    int         t       [2];
    int         cnt     [2];
    logic [7:0] pressed [2];
    logic [7:0] exp_btn [2];
    bit         exp_vld [2];
    bit         exp_chg [2];
    logic [7:0] next_pressed [2];

    function automatic int dv(int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic int piv(int g);
        return (g == 0) ? 100 : 10;
    endfunction

    // {latch, pulse, busy, valid, changed}
    function automatic logic [4:0] ctl(int g);
        return (g == 0) ? {latch0, pulse0, busy0, valid0, changed0}
                        : {latch1, pulse1, busy1, valid1, changed1};
    endfunction

    function automatic logic [7:0] btn(int g);
        return (g == 0) ? btn0 : btn1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreset(int g);
        active[g] = 0; t[g] = 0; cnt[g] = 0;
        exp_btn[g] = 8'h00; exp_vld[g] = 0; exp_chg[g] = 0;
    endtask

    task automatic mstep(int g);
        int d = dv(g);
        int p = piv(g);
        bit acc = 0;
        exp_vld[g] = 0;
        exp_chg[g] = 0;
        if (active[g]) begin
            if (t[g] == 17 * d) begin
                active[g]  = 0;
                exp_vld[g] = 1;
                exp_chg[g] = (pressed[g] != exp_btn[g]);
                exp_btn[g] = pressed[g];
            end else begin
                t[g]++;
            end
        end else if (start_v[g] || (auto_v[g] && cnt[g] == p - 1)) begin
            active[g]  = 1;
            t[g]       = 0;
            pressed[g] = next_pressed[g];
            acc        = 1;
        end
        if (acc || !auto_v[g]) cnt[g] = 0;
        else if (cnt[g] < p - 1) cnt[g]++;
    endtask

    // One clock: check and present data at negedge, advance model at posedge, return at posedge+2.
    task automatic tick();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            int d = dv(g);
            logic lat, pul;
            if (!reset_n) mreset(g);
            lat = active[g] && t[g] < 2 * d;
            pul = active[g] && t[g] >= 3 * d && t[g] < 17 * d && ((t[g] - 3 * d) % (2 * d)) < d;
            chk($sformatf("u%0d ctl", g), ctl(g), {lat, pul, active[g], exp_vld[g], exp_chg[g]});
            chk($sformatf("u%0d buttons", g), btn(g), exp_btn[g]);
            if (active[g] && t[g] >= 3 * d - 1 && ((t[g] - (3 * d - 1)) % (2 * d)) == 0)
                data_v[g] = ~pressed[g][7 - (t[g] - (3 * d - 1)) / (2 * d)];
            else
                data_v[g] = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            if (!reset_n) mreset(g);
            else mstep(g);
        end
        #2;
    endtask

    task automatic poll_once(int g, logic [7:0] val, logic exp_c);
        int n = 0, lat = 0, pul = 0, rises = 0, both = 0;
        int d = dv(g);
        logic prev = 1'b0;
        logic [4:0] c;
        next_pressed[g] = val;
        start_v[g] = 1'b1;
        tick();
        start_v[g] = 1'b0;
        c = ctl(g);
        while (!c[1] && n < 100) begin
            lat += int'(c[4]);
            pul += int'(c[3]);
            if (c[3] && !prev) rises++;
            prev = c[3];
            both += int'(c[4] & c[3]);
            tick();
            n++;
            c = ctl(g);
        end
        chk("valid latency", n, 17 * d + 1);
        chk("latch cycles", lat, 2 * d);
        chk("pulse high cycles", pul, 7 * d);
        chk("pulse count", rises, 7);
        chk("latch/pulse overlap", both, 0);
        chk("poll buttons", btn(g), val);
        chk("poll changed", c[0], exp_c);
    endtask

    task automatic wait_idle(int g);
        int n = 0;
        logic [4:0] c = ctl(g);
        while (c[2] && n < 200) begin
            tick();
            n++;
            c = ctl(g);
        end
        chk("idle timeout", c[2], 1'b0);
    endtask

    initial begin
        int r [3];
        int nr, gap, nv;
        logic [4:0] c;
        logic prev_busy;
        logic [7:0] v;

        reset_n = 1'b0;
        start_v = '0;
        auto_v  = '0;
        data_v  = '0;
        next_pressed[0] = 8'h00;
        next_pressed[1] = 8'h00;
        mreset(0);
        mreset(1);
        tick();
        chk("reset u0", {ctl(0), btn(0)}, 13'h0);
        chk("reset u1", {ctl(1), btn(1)}, 13'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // A + Start pressed, then the identical frame again
        poll_once(0, 8'h90, 1'b1);
        tick();
        poll_once(0, 8'h90, 1'b0);
        tick();

        // start during PULSE_HI is dropped
        next_pressed[0] = 8'h41;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (7) tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            c = ctl(0);
            nv += int'(c[1]);
            tick();
        end
        chk("valid count", nv, 1);
        chk("dropped-start buttons", btn0, 8'h41);

        // reset in the PULSE_LO of the fourth pair aborts the poll
        next_pressed[0] = 8'hA5;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (20) tick();
        reset_n = 1'b0;
        #1;
        chk("reset mid-poll", {ctl(0), btn(0)}, 13'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        v = 8'($urandom_range(1, 255));
        poll_once(0, v, 1'b1);
        tick();

        // auto polling, POLL_INTERVAL=100
        auto_v[0] = 1'b1;
        r = '{0, 0, 0};
        nr = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 450 && nr < 3; i++) begin
            tick();
            c = ctl(0);
            if (c[2] && !prev_busy) begin r[nr] = i; nr++; end
            prev_busy = c[2];
        end
        chk("auto u0 polls", nr, 3);
        chk("auto u0 spacing 1", r[1] - r[0], 100);
        chk("auto u0 spacing 2", r[2] - r[1], 100);
        auto_v[0] = 1'b0;
        wait_idle(0);

        // auto polling, POLL_INTERVAL=10 < poll length: back-to-back with one IDLE cycle
        next_pressed[1] = 8'h3C;
        auto_v[1] = 1'b1;
        r = '{0, 0, 0};
        nr = 0;
        gap = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 100 && nr < 3; i++) begin
            tick();
            c = ctl(1);
            if (c[2] && !prev_busy) begin r[nr] = i; nr++; end
            if (!c[2] && nr == 1) gap++;
            prev_busy = c[2];
        end
        chk("auto u1 polls", nr, 3);
        chk("auto u1 spacing", r[1] - r[0], 19);
        chk("auto u1 idle gap", gap, 1);
        auto_v[1] = 1'b0;
        wait_idle(1);
        tick();

        // CLK_DIV=1, everything pressed
        poll_once(1, 8'hFF, 1'b1);
        tick();

        // random traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            for (int g = 0; g < 2; g++) begin
                start_v[g] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 99) == 0) auto_v[g] = ~auto_v[g];
                next_pressed[g] = 8'($urandom);
            end
            reset_n = ($urandom_range(0, 699) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
